cache_dm_burst: RTL and testbench

//  Parametrised direct-mapped, write-through, no-write-allocate cache between the CPU and the MCU.

---
 rtl/cache_dm_burst.sv | 231 +++++++++++++++++++++++
 tb/tb_cache_dm_burst.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_dm_burst.sv
// cache_dm_burst: direct-mapped, write-through, no-write-allocate cache with
// burst line refill, virtually indexed / physically tagged.
// Optional TLB enabled by defining CACHE_VMEM_EN; without it paddr = vaddr.
module cache_dm_burst #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int IDX_W     = 8,
  parameter int LINE_LOG2 = 1,
  parameter int PAGE_W    = 12,
  parameter int TLB_IDX_W = 6,
  localparam int PPN_W    = ADDR_W - PAGE_W,
  localparam int VT_W     = PPN_W - TLB_IDX_W,
  localparam int TAG_W    = ADDR_W - IDX_W - LINE_LOG2 - 2
) (
  input  logic                      CPU_CLK,
  input  logic                      RST,
  input  logic                      cpu_req,
  input  logic                      cpu_we,
  input  logic [ADDR_W-1:0]         cpu_addr,
  input  logic [DATA_W-1:0]         cpu_datao,
  output logic [DATA_W-1:0]         cpu_datai,
  output logic                      cpu_busy_n,
  input  logic                      cpu_inhibit,
  input  logic                      dma_mcu_access,
  output logic                      mem_do_act,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_dataintomem,
  input  logic                      mem_ack,
  input  logic                      mem_rvalid,
  input  logic [DATA_W-1:0]         mem_datafrommem,
  input  logic                      VMEM_ACT,
  input  logic                      WE_TLB,
  input  logic [TLB_IDX_W-1:0]      tlb_addr,
  input  logic [1+VT_W+PPN_W-1:0]   tlb_wdata,
  output logic                      TLB_write_busy,
  output logic                      MMU_FAULT
);

  localparam int LINES  = 1 << IDX_W;
  localparam int WORDS  = 1 << (IDX_W + LINE_LOG2);
  localparam int IDX_LO = LINE_LOG2 + 2;
  localparam int TAG_LO = IDX_W + LINE_LOG2 + 2;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_FILL_REQ, S_FILL_DATA, S_WR_REQ, S_DONE
  } state_t;

  state_t                  state;
  logic [ADDR_W-1:0]       addr_r;
  logic                    we_r;
  logic [DATA_W-1:0]       wdata_r;
  logic [LINES-1:0]        line_valid;
  logic [TAG_W-1:0]        tag_mem  [LINES];
  logic [DATA_W-1:0]       data_mem [WORDS];
  logic                    rd_valid;
  logic [TAG_W-1:0]        rd_tag;
  logic [DATA_W-1:0]       rd_word;
  logic [DATA_W-1:0]       cap_word;
  logic [LINE_LOG2-1:0]    beat_cnt;

  logic [ADDR_W-1:0]       paddr;
  logic                    fault;
  logic                    tlb_we_acc;
  logic                    req_acc;
  logic                    hit;
  logic                    lk_go;

  assign req_acc = (state == S_IDLE) && cpu_req && !tlb_we_acc;

`ifdef CACHE_VMEM_EN
  logic [TLB_IDX_W-1:0]    tlb_valid_unused_idx;
  logic [(1<<TLB_IDX_W)-1:0] tlb_valid;
  logic [VT_W-1:0]         tlb_vt  [1<<TLB_IDX_W];
  logic [PPN_W-1:0]        tlb_ppn [1<<TLB_IDX_W];
  logic                    rd_tlb_valid;
  logic [VT_W-1:0]         rd_tlb_vt;
  logic [PPN_W-1:0]        rd_tlb_ppn;
  logic                    vmem_r;

  assign tlb_valid_unused_idx = '0;
  assign tlb_we_acc     = WE_TLB && (state == S_IDLE);
  assign TLB_write_busy = (state != S_IDLE);

  // TLB valid bits, translation-enable capture and valid read port
  always_ff @(posedge CPU_CLK or negedge RST) begin
    if (!RST) begin
      tlb_valid    <= '0;
      rd_tlb_valid <= 1'b0;
      vmem_r       <= 1'b0;
    end else begin
      if (tlb_we_acc)
        tlb_valid[tlb_addr] <= tlb_wdata[VT_W+PPN_W];
      if (state == S_IDLE)
        rd_tlb_valid <= tlb_valid[cpu_addr[PAGE_W+TLB_IDX_W-1:PAGE_W]];
      if (req_acc)
        vmem_r <= VMEM_ACT;
    end
  end

  // TLB vtag/ppn storage with synchronous read indexed by the VPN
  always_ff @(posedge CPU_CLK) begin
    if (tlb_we_acc) begin
      tlb_vt[tlb_addr]  <= tlb_wdata[VT_W+PPN_W-1:PPN_W];
      tlb_ppn[tlb_addr] <= tlb_wdata[PPN_W-1:0];
    end
    if (state == S_IDLE) begin
      rd_tlb_vt  <= tlb_vt[cpu_addr[PAGE_W+TLB_IDX_W-1:PAGE_W]];
      rd_tlb_ppn <= tlb_ppn[cpu_addr[PAGE_W+TLB_IDX_W-1:PAGE_W]];
    end
  end

  assign paddr = vmem_r ? {rd_tlb_ppn, addr_r[PAGE_W-1:0]} : addr_r;
  assign fault = vmem_r &&
                 !(rd_tlb_valid && (rd_tlb_vt == addr_r[ADDR_W-1:PAGE_W+TLB_IDX_W]));
`else
  logic unused_tlb;
  assign unused_tlb     = ^{VMEM_ACT, WE_TLB, tlb_addr, tlb_wdata};
  assign tlb_we_acc     = 1'b0;
  assign TLB_write_busy = 1'b0;
  assign paddr          = addr_r;
  assign fault          = 1'b0;
`endif

  logic unused_pbits;
  assign unused_pbits = ^paddr[1:0];

  assign hit   = rd_valid && (rd_tag == paddr[ADDR_W-1:TAG_LO]);
  assign lk_go = (state == S_LOOKUP) && !cpu_inhibit && !fault;

  // CPU-facing handshake: hit/fault/inhibit resolve within the LOOKUP cycle
  always_comb begin
    cpu_busy_n = 1'b0;
    cpu_datai  = '0;
    MMU_FAULT  = 1'b0;
    mem_do_act = 1'b0;
    case (state)
      S_IDLE:     cpu_busy_n = !(tlb_we_acc && cpu_req);
      S_LOOKUP: begin
        MMU_FAULT  = !cpu_inhibit && fault;
        cpu_busy_n = cpu_inhibit || fault || (!we_r && hit);
        if (lk_go && !we_r && hit)
          cpu_datai = rd_word;
      end
      S_FILL_REQ: mem_do_act = dma_mcu_access;
      S_WR_REQ:   mem_do_act = dma_mcu_access;
      S_DONE: begin
        cpu_busy_n = 1'b1;
        if (!we_r)
          cpu_datai = cap_word;
      end
      default: ;
    endcase
  end

  // Main controller: request capture, miss/write sequencing, burst refill
  always_ff @(posedge CPU_CLK or negedge RST) begin
    if (!RST) begin
      state           <= S_IDLE;
      addr_r          <= '0;
      we_r            <= 1'b0;
      wdata_r         <= '0;
      line_valid      <= '0;
      rd_valid        <= 1'b0;
      beat_cnt        <= '0;
      cap_word        <= '0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_dataintomem <= '0;
    end else begin
      case (state)
        S_IDLE: if (req_acc) begin
          addr_r   <= cpu_addr;
          we_r     <= cpu_we;
          wdata_r  <= cpu_datao;
          rd_valid <= line_valid[cpu_addr[TAG_LO-1:IDX_LO]];
          state    <= S_LOOKUP;
        end
        S_LOOKUP: begin
          if (!lk_go) begin
            state <= S_IDLE;
          end else if (we_r) begin
            mem_we          <= 1'b1;
            mem_addr        <= {2'b00, paddr[ADDR_W-1:2]};
            mem_dataintomem <= wdata_r;
            state           <= S_WR_REQ;
          end else if (hit) begin
            state <= S_IDLE;
          end else begin
            mem_we   <= 1'b0;
            mem_addr <= {2'b00, paddr[ADDR_W-1:IDX_LO], {LINE_LOG2{1'b0}}};
            beat_cnt <= '0;
            state    <= S_FILL_REQ;
          end
        end
        S_FILL_REQ: if (dma_mcu_access && mem_ack) state <= S_FILL_DATA;
        S_FILL_DATA: if (mem_rvalid) begin
          if (beat_cnt == addr_r[IDX_LO-1:2])
            cap_word <= mem_datafrommem;
          beat_cnt <= beat_cnt + 1'b1;
          if (&beat_cnt) begin
            line_valid[addr_r[TAG_LO-1:IDX_LO]] <= 1'b1;
            state <= S_DONE;
          end
        end
        S_WR_REQ: if (dma_mcu_access && mem_ack) begin
          mem_we <= 1'b0;
          state  <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Tag/data arrays: synchronous read in IDLE, write-hit update, refill beats
  always_ff @(posedge CPU_CLK) begin
    if (state == S_IDLE) begin
      rd_word <= data_mem[cpu_addr[TAG_LO-1:2]];
      rd_tag  <= tag_mem[cpu_addr[TAG_LO-1:IDX_LO]];
    end
    if (lk_go && we_r && hit)
      data_mem[addr_r[TAG_LO-1:2]] <= wdata_r;
    if (state == S_FILL_DATA && mem_rvalid) begin
      data_mem[{addr_r[TAG_LO-1:IDX_LO], beat_cnt}] <= mem_datafrommem;
      if (&beat_cnt)
        tag_mem[addr_r[TAG_LO-1:IDX_LO]] <= paddr[ADDR_W-1:TAG_LO];
    end
  end

endmodule

// File: tb/tb_cache_dm_burst.sv
// Directed bench for cache_dm_burst (default parameters); TLB steps are
// compiled only when CACHE_VMEM_EN is defined.
module tb_cache_dm_burst;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int TLB_IDX_W = 6;
  localparam int PPN_W = 20;
  localparam int VT_W = 14;

  logic                    CPU_CLK;
  logic                    RST;
  logic                    cpu_req, cpu_we, cpu_inhibit;
  logic [ADDR_W-1:0]       cpu_addr;
  logic [DATA_W-1:0]       cpu_datao, cpu_datai;
  logic                    cpu_busy_n;
  logic                    dma_mcu_access;
  logic                    mem_do_act, mem_we, mem_ack, mem_rvalid;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_dataintomem, mem_datafrommem;
  logic                    VMEM_ACT, WE_TLB;
  logic [TLB_IDX_W-1:0]    tlb_addr;
  logic [1+VT_W+PPN_W-1:0] tlb_wdata;
  logic                    TLB_write_busy, MMU_FAULT;

  int checks = 0;
  int errors = 0;

  cache_dm_burst dut (
    .CPU_CLK(CPU_CLK), .RST(RST),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_datao(cpu_datao), .cpu_datai(cpu_datai), .cpu_busy_n(cpu_busy_n),
    .cpu_inhibit(cpu_inhibit), .dma_mcu_access(dma_mcu_access),
    .mem_do_act(mem_do_act), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_dataintomem(mem_dataintomem), .mem_ack(mem_ack),
    .mem_rvalid(mem_rvalid), .mem_datafrommem(mem_datafrommem),
    .VMEM_ACT(VMEM_ACT), .WE_TLB(WE_TLB), .tlb_addr(tlb_addr),
    .tlb_wdata(tlb_wdata), .TLB_write_busy(TLB_write_busy), .MMU_FAULT(MMU_FAULT)
  );

  initial begin
    CPU_CLK = 1'b0;
    forever #5 CPU_CLK = ~CPU_CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CPU_CLK);
    @(negedge CPU_CLK);
  endtask

  initial begin
    RST = 1'b0; cpu_req = 0; cpu_we = 0; cpu_inhibit = 0; cpu_addr = '0;
    cpu_datao = '0; dma_mcu_access = 1; mem_ack = 0; mem_rvalid = 0;
    mem_datafrommem = '0; VMEM_ACT = 0; WE_TLB = 0; tlb_addr = '0; tlb_wdata = '0;
    #1;
    chk("rst_busy_n", 32'(cpu_busy_n), 32'd1);
    chk("rst_datai", cpu_datai, 32'h0);
    chk("rst_do_act", 32'(mem_do_act), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_dataintomem, 32'h0);
    chk("rst_fault", 32'(MMU_FAULT), 32'd0);
    chk("rst_tlb_busy", 32'(TLB_write_busy), 32'd0);
    @(negedge CPU_CLK);
    RST = 1'b1;
    tick();

    // read miss 0x100, ack on the second FILL_REQ cycle, beats A0/A1
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100;
    tick();
    cpu_req = 0;
    chk("rd_miss_busy", 32'(cpu_busy_n), 32'd0);
    tick();
    chk("fill_do_act", 32'(mem_do_act), 32'd1);
    chk("fill_we", 32'(mem_we), 32'd0);
    chk("fill_addr", mem_addr, 32'h40);
    tick();
    chk("fill_hold_addr", mem_addr, 32'h40);
    mem_ack = 1;
    tick();
    mem_ack = 0;
    chk("fill_data_no_act", 32'(mem_do_act), 32'd0);
    mem_rvalid = 1; mem_datafrommem = 32'hA0;
    tick();
    mem_datafrommem = 32'hA1;
    tick();
    mem_rvalid = 0;
    chk("done_busy", 32'(cpu_busy_n), 32'd1);
    chk("done_datai", cpu_datai, 32'hA0);
    tick();
    cpu_req = 1; cpu_addr = 32'h100;
    tick();
    cpu_req = 0;
    chk("hit100_busy", 32'(cpu_busy_n), 32'd1);
    chk("hit100_data", cpu_datai, 32'hA0);
    tick();
    cpu_req = 1; cpu_addr = 32'h104;
    tick();
    cpu_req = 0;
    chk("hit104_data", cpu_datai, 32'hA1);
    tick();

    // write hit 0x104 = DEAD, ack delayed three cycles
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h104; cpu_datao = 32'hDEAD;
    tick();
    cpu_req = 0;
    chk("wr_lookup_busy", 32'(cpu_busy_n), 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("wr_do_act", 32'(mem_do_act), 32'd1);
      chk("wr_we", 32'(mem_we), 32'd1);
      chk("wr_addr", mem_addr, 32'h41);
      chk("wr_data", mem_dataintomem, 32'hDEAD);
      chk("wr_busy", 32'(cpu_busy_n), 32'd0);
      if (i == 2) mem_ack = 1;
      tick();
    end
    mem_ack = 0;
    chk("wr_done_busy", 32'(cpu_busy_n), 32'd1);
    tick();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h104;
    tick();
    cpu_req = 0;
    chk("rd_dead_busy", 32'(cpu_busy_n), 32'd1);
    chk("rd_dead_data", cpu_datai, 32'hDEAD);
    tick();

    // write miss 0x2000: memory write only
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h2000; cpu_datao = 32'h1234;
    tick();
    cpu_req = 0;
    tick();
    chk("wmiss_we", 32'(mem_we), 32'd1);
    chk("wmiss_addr", mem_addr, 32'h800);
    mem_ack = 1;
    tick();
    mem_ack = 0;
    tick();
    // read 0x2000 must miss; grant withheld for 5 cycles while ack is high
    cpu_req = 1; cpu_we = 0;
    tick();
    cpu_req = 0;
    chk("rd2000_miss", 32'(cpu_busy_n), 32'd0);
    tick();
    dma_mcu_access = 0; mem_ack = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("nogrant_act", 32'(mem_do_act), 32'd0);
      chk("nogrant_busy", 32'(cpu_busy_n), 32'd0);
      tick();
    end
    dma_mcu_access = 1;
    #1;
    chk("grant_act", 32'(mem_do_act), 32'd1);
    chk("grant_addr", mem_addr, 32'h800);
    chk("grant_we", 32'(mem_we), 32'd0);
    tick();
    mem_ack = 0;
    mem_rvalid = 1; mem_datafrommem = 32'h55;
    tick();
    mem_datafrommem = 32'h66;
    tick();
    mem_rvalid = 0;
    chk("fill2000_data", cpu_datai, 32'h55);
    tick();

    // reset after first beat of a fill of 0x300
    cpu_req = 1; cpu_addr = 32'h300;
    tick();
    cpu_req = 0;
    tick();
    chk("fill300_addr", mem_addr, 32'hC0);
    mem_ack = 1;
    tick();
    mem_ack = 0;
    mem_rvalid = 1; mem_datafrommem = 32'h77;
    tick();
    mem_rvalid = 0;
    #2 RST = 1'b0;
    #1;
    chk("arst_addr", mem_addr, 32'h0);
    chk("arst_busy", 32'(cpu_busy_n), 32'd1);
    chk("arst_act", 32'(mem_do_act), 32'd0);
    @(negedge CPU_CLK);
    RST = 1'b1;
    tick();

    // inhibited request to an invalid line: no stall, no memory action
    cpu_req = 1; cpu_addr = 32'h100; cpu_inhibit = 1;
    tick();
    cpu_req = 0;
    chk("inh_busy", 32'(cpu_busy_n), 32'd1);
    tick();
    cpu_inhibit = 0;
    chk("inh_no_act", 32'(mem_do_act), 32'd0);
    chk("inh_idle_busy", 32'(cpu_busy_n), 32'd1);
    tick();

    // 0x300 re-read after reset must miss
    cpu_req = 1; cpu_addr = 32'h300;
    tick();
    cpu_req = 0;
    chk("rd300_miss", 32'(cpu_busy_n), 32'd0);
    tick();
    chk("refill300_addr", mem_addr, 32'hC0);
    mem_ack = 1;
    tick();
    mem_ack = 0;
    mem_rvalid = 1; mem_datafrommem = 32'h88;
    tick();
    mem_datafrommem = 32'h99;
    tick();
    mem_rvalid = 0;
    chk("refill300_data", cpu_datai, 32'h88);
    tick();

`ifdef CACHE_VMEM_EN
    // TLB write collides with a request: write wins, request re-looked-up
    WE_TLB = 1; tlb_addr = 6'd1; tlb_wdata = {1'b1, 14'h0, 20'h00005};
    cpu_req = 1; cpu_addr = 32'h1010; VMEM_ACT = 1;
    #1;
    chk("tlbwr_busy", 32'(cpu_busy_n), 32'd0);
    tick();
    WE_TLB = 0;
    chk("tlbwr_idle_busy", 32'(cpu_busy_n), 32'd1);
    tick();
    cpu_req = 0;
    chk("vm_fault0", 32'(MMU_FAULT), 32'd0);
    chk("vm_miss", 32'(cpu_busy_n), 32'd0);
    chk("vm_tlb_busy", 32'(TLB_write_busy), 32'd1);
    tick();
    chk("vm_addr", mem_addr, 32'h1404);
    mem_ack = 1;
    tick();
    mem_ack = 0;
    mem_rvalid = 1; mem_datafrommem = 32'hB0;
    tick();
    mem_datafrommem = 32'hB1;
    tick();
    mem_rvalid = 0;
    chk("vm_data", cpu_datai, 32'hB0);
    tick();
    cpu_req = 1; cpu_addr = 32'h41010;
    tick();
    cpu_req = 0;
    chk("vm_fault", 32'(MMU_FAULT), 32'd1);
    chk("vm_fault_busy", 32'(cpu_busy_n), 32'd1);
    chk("vm_fault_data", cpu_datai, 32'h0);
    tick();
    chk("vm_fault_pulse", 32'(MMU_FAULT), 32'd0);
    chk("vm_fault_no_act", 32'(mem_do_act), 32'd0);
    VMEM_ACT = 0;
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
